// File: rtl/hmac_msg_block_packer_if.sv
// Handshake bundle between the message source, the block packer and its consumers.
// slave is the packer side; master is the source/consumer side.
interface hmac_msg_block_packer_if #(
  parameter int BLOCK_WORDS = 16,
  parameter int LEN_W       = 128
);
  logic                        in_valid;
  logic                        in_ready;
  logic [63:0]                 in_data;
  logic                        in_last;
  logic [3:0]                  in_bytes;
  logic                        out_valid;
  logic                        out_ready;
  logic [64*BLOCK_WORDS-1:0]   out_block;
  logic                        out_last;
  logic [LEN_W-1:0]            out_len;

  modport slave (
    input  in_valid, in_data, in_last, in_bytes, out_ready,
    output in_ready, out_valid, out_block, out_last, out_len
  );

  modport master (
    output in_valid, in_data, in_last, in_bytes, out_ready,
    input  in_ready, out_valid, out_block, out_last, out_len
  );
endinterface

// File: rtl/hmac_msg_block_packer.sv
// Packs a stream of 64-bit big-endian message words into 1024-bit SHA-384 blocks
// and tracks the running message bit length for the HMAC padding stage.
module hmac_msg_block_packer #(
  parameter int BLOCK_WORDS = 16,
  parameter int LEN_W       = 128
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  hmac_msg_block_packer_if.slave bus
);
  localparam int BLK_W = 64 * BLOCK_WORDS;
  localparam int IDX_W = $clog2(BLOCK_WORDS);

  typedef enum logic {S_FILL, S_HOLD} state_e;

  state_e             state_q, state_d;
  logic [BLK_W-1:0]   buf_q, buf_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               last_q, last_d;

  logic               in_rdy;
  logic               accept;
  logic [3:0]         nbytes;
  logic [63:0]        word;

  function automatic logic [3:0] sat_bytes(input logic [3:0] b);
    return (b > 4'd8) ? 4'd8 : b;
  endfunction

  // Keep the top n bytes of a big-endian word, zero the rest.
  function automatic logic [63:0] keep_bytes(input logic [63:0] w, input logic [3:0] n);
    logic [6:0] sh;
    sh = 7'd64 - {n, 3'b000};
    return w & (~64'd0 << sh);
  endfunction

  assign in_rdy = (state_q == S_FILL) & ~rst;
  assign accept = bus.in_valid & in_rdy;
  assign nbytes = sat_bytes(bus.in_bytes);
  assign word   = bus.in_last ? keep_bytes(bus.in_data, nbytes) : bus.in_data;

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    idx_d   = idx_q;
    len_d   = len_q;
    last_d  = last_q;
    if (clear) begin
      state_d = S_FILL;
      buf_d   = '0;
      idx_d   = '0;
      len_d   = '0;
      last_d  = 1'b0;
    end else if (state_q == S_FILL) begin
      if (accept) begin
        for (int k = 0; k < BLOCK_WORDS; k++) begin
          if (IDX_W'(k) == idx_q) buf_d[BLK_W-1-64*k -: 64] = word;
        end
        len_d = len_q + (bus.in_last ? LEN_W'({nbytes, 3'b000}) : LEN_W'(64));
        idx_d = idx_q + 1'b1;
        if (bus.in_last || idx_q == IDX_W'(BLOCK_WORDS - 1)) begin
          state_d = S_HOLD;
          last_d  = bus.in_last;
        end
      end
    end else if (bus.out_ready) begin
      // Slots beyond a short final word rely on the buffer being zeroed here.
      state_d = S_FILL;
      buf_d   = '0;
      idx_d   = '0;
      last_d  = 1'b0;
      if (last_q) len_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FILL;
      buf_q   <= '0;
      idx_q   <= '0;
      len_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      last_q  <= last_d;
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = (state_q == S_HOLD);
  assign bus.out_block = buf_q;
  assign bus.out_last  = last_q;
  assign bus.out_len   = len_q;
endmodule

// File: tb/tb_hmac_msg_block_packer.sv
// Randomized bench for hmac_msg_block_packer against a message-level block model.
module tb_hmac_msg_block_packer;
  logic clk;
  logic rst;
  logic clear;

  hmac_msg_block_packer_if #(.BLOCK_WORDS(16), .LEN_W(128)) bus ();

  hmac_msg_block_packer #(.BLOCK_WORDS(16), .LEN_W(128)) dut (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [63:0] msg [0:63];

  // Expected block blk of a message of nwords words whose last word has lastb bytes.
  function automatic logic [1023:0] exp_block(input int nwords, input logic [3:0] lastb, input int blk);
    logic [1023:0] r;
    logic [63:0]   w;
    int            n;
    r = '0;
    n = (lastb > 4'd8) ? 8 : int'(lastb);
    for (int k = 0; k < 16; k++) begin
      int i;
      i = blk * 16 + k;
      if (i < nwords) begin
        w = msg[i];
        if (i == nwords - 1)
          for (int by = 0; by < 8; by++)
            if (by >= n) w[63-8*by -: 8] = 8'h00;
        r[1023-64*k -: 64] = w;
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] exp_len(input int nwords, input logic [3:0] lastb, input int blk);
    int n;
    int nblk;
    n    = (lastb > 4'd8) ? 8 : int'(lastb);
    nblk = (nwords + 15) / 16;
    if (blk == nblk - 1) return 128'(64 * (nwords - 1) + 8 * n);
    return 128'(1024 * (blk + 1));
  endfunction

  function automatic int first_diff(input logic [1023:0] a, input logic [1023:0] b);
    for (int k = 0; k < 16; k++)
      if (a[1023-64*k -: 64] !== b[1023-64*k -: 64]) return k;
    return 0;
  endfunction

  // Drive one message (msg[0..nwords-1]) and check every block and the valid timing.
  task automatic run_msg(input string name, input int nwords, input logic [3:0] lastb,
                         input int stall, input bit gaps);
    int            wi, blk, nblk, cyc, held;
    bit            hold_m;
    logic [1023:0] eb;
    logic [127:0]  el;
    wi = 0; blk = 0; cyc = 0; held = 0; hold_m = 0;
    nblk = (nwords + 15) / 16;
    while (blk < nblk && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      total++;
      if (bus.out_valid !== hold_m)
        begin bad++; $display("FAIL %s out_valid blk=%0d got=%b want=%b", name, blk, bus.out_valid, hold_m); end
      if (hold_m) begin
        eb = exp_block(nwords, lastb, blk);
        el = exp_len(nwords, lastb, blk);
        total++;
        if (bus.out_block !== eb) begin
          int k;
          k = first_diff(bus.out_block, eb);
          bad++;
          $display("FAIL %s out_block blk=%0d word%0d got=%h want=%h", name, blk, k,
                   bus.out_block[1023-64*k -: 64], eb[1023-64*k -: 64]);
        end
        total++;
        if (bus.out_len !== el)
          begin bad++; $display("FAIL %s out_len blk=%0d got=%0d want=%0d", name, blk, bus.out_len, el); end
        total++;
        if (bus.out_last !== (blk == nblk - 1))
          begin bad++; $display("FAIL %s out_last blk=%0d got=%b want=%b", name, blk, bus.out_last, blk == nblk - 1); end
        total++;
        if (bus.in_ready !== 1'b0)
          begin bad++; $display("FAIL %s in_ready_hold blk=%0d got=%b want=0", name, blk, bus.in_ready); end
        if (stall < 0) bus.out_ready = 1'($urandom_range(0, 1));
        else           bus.out_ready = (held >= stall);
        if (bus.out_ready) begin blk++; hold_m = 0; held = 0; end
        else held++;
      end else begin
        bus.out_ready = 1'($urandom_range(0, 1));
      end
      if (wi < nwords && !(gaps && $urandom_range(0, 3) == 0)) begin
        bus.in_valid = 1'b1;
        bus.in_data  = msg[wi];
        bus.in_last  = (wi == nwords - 1);
        bus.in_bytes = (wi == nwords - 1) ? lastb : 4'($urandom_range(0, 15));
      end else begin
        bus.in_valid = 1'b0;
        bus.in_data  = {$urandom, $urandom};
        bus.in_last  = 1'($urandom_range(0, 1));
        bus.in_bytes = 4'($urandom_range(0, 15));
      end
      if (bus.in_valid && bus.in_ready) begin
        if (bus.in_last || (wi % 16) == 15) hold_m = 1;
        wi++;
      end
    end
    total++;
    if (blk != nblk)
      begin bad++; $display("FAIL %s timeout blocks got=%0d want=%0d", name, blk, nblk); end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      total++;
      if (bus.out_valid !== 1'b0)
        begin bad++; $display("FAIL %s extra_block got=%b want=0", name, bus.out_valid); end
      @(negedge clk);
    end
  endtask

  task automatic feed_words(input int n);
    int got, cyc;
    got = 0; cyc = 0;
    while (got < n && cyc < 500) begin
      @(negedge clk);
      cyc++;
      bus.in_valid = 1'b1;
      bus.in_data  = {$urandom, $urandom};
      bus.in_last  = 1'b0;
      bus.in_bytes = 4'd0;
      if (bus.in_ready) got++;
    end
    total++;
    if (got < n) begin bad++; $display("FAIL feed_words accepted got=%0d want=%0d", got, n); end
  endtask

  task automatic set_abc();
    msg[0] = 64'h616263FFFFFFFFFF;
  endtask

  task automatic test_reset();
    rst = 1'b1; clear = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0; bus.in_bytes = '0;
    bus.out_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    total++; if (bus.in_ready !== 1'b0)  begin bad++; $display("FAIL reset in_ready got=%b want=0", bus.in_ready); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset out_valid got=%b want=0", bus.out_valid); end
    total++; if (bus.out_last !== 1'b0)  begin bad++; $display("FAIL reset out_last got=%b want=0", bus.out_last); end
    total++; if (bus.out_len !== '0)     begin bad++; $display("FAIL reset out_len got=%0d want=0", bus.out_len); end
    total++; if (bus.out_block !== '0)   begin bad++; $display("FAIL reset out_block high=%h want=0", bus.out_block[1023:960]); end
    rst = 1'b0;
    @(negedge clk);
    total++; if (bus.in_ready !== 1'b1)  begin bad++; $display("FAIL post_reset in_ready got=%b want=1", bus.in_ready); end
  endtask

  task automatic test_empty();
    msg[0] = {$urandom, $urandom};
    run_msg("empty", 1, 4'd0, 0, 0);
  endtask

  task automatic test_abc();
    set_abc();
    run_msg("abc", 1, 4'd3, 1, 0);
    msg[0] = {$urandom, $urandom};
    run_msg("bytes_gt8", 1, 4'd13, 0, 0);
  endtask

  task automatic test_block_boundary();
    for (int i = 0; i < 16; i++) msg[i] = {$urandom, $urandom};
    run_msg("full_block", 16, 4'd8, 0, 0);
  endtask

  task automatic test_17_words();
    for (int i = 0; i < 16; i++) msg[i] = {$urandom, $urandom};
    msg[16] = 64'h0123456789ABCDEF;
    run_msg("words17", 17, 4'd8, 0, 0);
    for (int i = 0; i < 20; i++) msg[i] = {$urandom, $urandom};
    run_msg("zero_tail", 20, 4'd0, 0, 1);
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 36; i++) msg[i] = {$urandom, $urandom};
    run_msg("backpressure", 36, 4'd5, 5, 0);
  endtask

  task automatic test_clear();
    feed_words(7);
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_data = {$urandom, $urandom}; bus.in_last = 1'b1; bus.in_bytes = 4'd8;
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0; bus.in_valid = 1'b0;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL clear_fill out_valid got=%b want=0", bus.out_valid); end
    set_abc();
    run_msg("clear_fill_abc", 1, 4'd3, 0, 0);
    feed_words(16);
    @(negedge clk);
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL clear_hold pre out_valid got=%b want=1", bus.out_valid); end
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL clear_hold out_valid got=%b want=0", bus.out_valid); end
    run_msg("clear_hold_abc", 1, 4'd3, 0, 0);
  endtask

  task automatic test_async_reset();
    feed_words(5);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    total++; if (bus.in_ready !== 1'b0)  begin bad++; $display("FAIL arst_fill in_ready got=%b want=0", bus.in_ready); end
    total++; if (bus.out_block !== '0)   begin bad++; $display("FAIL arst_fill out_block high=%h want=0", bus.out_block[1023:960]); end
    @(negedge clk);
    rst = 1'b0;
    feed_words(16);
    @(negedge clk);
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL arst_hold pre out_valid got=%b want=1", bus.out_valid); end
    #2 rst = 1'b1;
    #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL arst_hold out_valid got=%b want=0", bus.out_valid); end
    total++; if (bus.out_len !== '0)     begin bad++; $display("FAIL arst_hold out_len got=%0d want=0", bus.out_len); end
    total++; if (bus.out_block !== '0)   begin bad++; $display("FAIL arst_hold out_block high=%h want=0", bus.out_block[1023:960]); end
    @(negedge clk);
    rst = 1'b0;
    set_abc();
    run_msg("arst_abc", 1, 4'd3, 0, 0);
  endtask

  task automatic test_random();
    for (int m = 0; m < 8; m++) begin
      int          nw;
      logic [3:0]  lb;
      nw = $urandom_range(1, 40);
      lb = 4'($urandom_range(0, 15));
      for (int i = 0; i < nw; i++) msg[i] = {$urandom, $urandom};
      run_msg("random", nw, lb, -1, 1);
    end
  endtask

  initial begin
    test_reset();
    test_empty();
    test_abc();
    test_block_boundary();
    test_17_words();
    test_backpressure();
    test_clear();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
